osc_index_gen: RTL and testbench
================================

OSC_INDEX_GEN -- requirements
Module: osc_index_gen

Interface
REQ-001 SHALL have parameter NUM_OSCILLATORS, default 4, number of oscillator voices.
REQ-002 SHALL have parameter WW_WIDTH, default 18, width of sample index and wave width.
REQ-003 SHALL have parameter INC_WIDTH, default 16, width of per-oscillator phase increment.
REQ-004 SHALL have parameter PHASE_FRAC, default 8, fractional bits of phase increment and accumulator.
REQ-005 SHALL have port clk_in  input  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port sample_tick_in  input  1  one-cycle pulse at audio sample rate.
REQ-008 SHALL have port wave_width_in  input  WW_WIDTH  active wave length in samples.
REQ-009 SHALL have port ui_update_trig_in  input  1  pulse: wave memory reloaded, restart all phases.
REQ-010 SHALL have port note_on_in  input  NUM_OSCILLATORS  per-oscillator gate.
REQ-011 SHALL have port phase_inc_in  input  INC_WIDTH x NUM_OSCILLATORS  unsigned increment, PHASE_FRAC fractional bits.
REQ-012 SHALL have port osc_is_on_out  output  NUM_OSCILLATORS  oscillator active, drives wave memory read enable.
REQ-013 SHALL have port osc_index_out  output  WW_WIDTH x NUM_OSCILLATORS  playback sample index.
REQ-014 SHALL have port update_done_out  output  1  one-cycle pulse when all indices are updated.
REQ-015 SHALL have port busy_out  output  1  high while an update pass is in progress.
REQ-016 SHALL have port tick_overrun_out  output  1  sticky: tick arrived while busy.

Function
REQ-017 SHALL keep one accumulator per oscillator of WW_WIDTH+PHASE_FRAC bits; index = accumulator integer part.
REQ-018 SHALL implement FSM IDLE -> UPDATE -> DONE -> IDLE.
REQ-019 IDLE: on sample_tick_in, SHALL latch wave_width_in and pending-restart flag, clear slot counter, enter UPDATE.
REQ-020 UPDATE: SHALL service exactly one oscillator per cycle, slot 0 to NUM_OSCILLATORS-1, then enter DONE.
REQ-021 DONE: SHALL assert update_done_out for exactly one cycle, then return to IDLE; pass latency tick-to-done = NUM_OSCILLATORS+1 cycles.
REQ-022 busy_out SHALL be high in UPDATE and DONE, low in IDLE.
REQ-023 Per slot, note_on_in[i]=0: accumulator, osc_index_out[i], osc_is_on_out[i] SHALL become 0.
REQ-024 Per slot, note_on_in[i]=1 and osc_is_on_out[i]=0 (note start): accumulator and index SHALL become 0, osc_is_on_out[i] SHALL become 1.
REQ-025 Per slot, note running: next = accumulator + zero-extended phase_inc_in[i]; if next integer part >= latched width, subtract width<<PHASE_FRAC once; if result still >= width, accumulator SHALL become 0.
REQ-026 Addition SHALL be computed one bit wider than the accumulator so carry-out counts as >= width.
REQ-027 Latched width 0: all serviced oscillators SHALL output index 0 and osc_is_on_out 0.
REQ-028 ui_update_trig_in SHALL set a pending-restart flag; the next pass SHALL zero every running accumulator and index (is_on unchanged), then clear the flag.
REQ-029 ui_update_trig_in coincident with sample_tick_in in IDLE SHALL apply to that pass.
REQ-030 sample_tick_in while busy_out=1 SHALL be ignored and SHALL set tick_overrun_out.
REQ-031 osc_index_out and osc_is_on_out SHALL be registered and change only in the cycle their slot is serviced.
REQ-032 wave_width_in changes mid-pass SHALL not affect the current pass.

Reset
REQ-033 With rst_in=0 at a clock edge, all accumulators, osc_index_out, osc_is_on_out, update_done_out, busy_out, tick_overrun_out, pending flag SHALL become 0 and FSM SHALL enter IDLE.
REQ-034 Reset mid-pass SHALL abort the pass with no update_done_out pulse.

Verification
REQ-035 N=4, width 1000, osc0 on, inc 0x0180 (1.5): 4 ticks -> osc_index_out[0] = 0,1,3,4; done pulse 5 cycles after each tick.
REQ-036 Width 10, inc 0x0300 (3.0), running from index 9 -> next index 2; inc 0x1400 (20.0) from index 9 -> index 0.
REQ-037 note_on 1->0 -> index 0, is_on 0 at slot service; 0->1 -> index 0, is_on 1; next tick advances by inc.
REQ-038 ui_update_trig_in with 3 running oscillators at nonzero indices -> all indices 0 after next pass, is_on remains 1.
REQ-039 Second tick 2 cycles after first -> ignored, tick_overrun_out=1, single done pulse; rst_in=0 clears it.
REQ-040 rst_in=0 in UPDATE slot 2 -> all outputs 0 next cycle, no done pulse, busy_out=0.

Source files
------------

// File: rtl/osc_index_gen.sv
// osc_index_gen
// Generates playback sample indices for a bank of wavetable oscillators.
// Each oscillator keeps a fixed-point phase accumulator (integer part is the
// sample index, PHASE_FRAC fractional bits). On every audio sample tick one
// update pass walks the oscillators, one slot per clock, then pulses
// update_done_out.
//
// Ports
//   clk_in             system clock, all logic on the rising edge
//   rst_in             synchronous active-low reset
//   sample_tick_in     one-cycle pulse at the audio sample rate; starts a pass
//   wave_width_in      active wave length in samples (latched at pass start)
//   ui_update_trig_in  pulse: wave memory reloaded, restart all running phases
//   note_on_in         per-oscillator gate
//   phase_inc_in       per-oscillator unsigned increment, oscillator i at
//                      bits [i*INC_WIDTH +: INC_WIDTH]
//   osc_is_on_out      per-oscillator active flag (wave memory read enable)
//   osc_index_out      per-oscillator sample index, oscillator i at
//                      bits [i*WW_WIDTH +: WW_WIDTH]
//   update_done_out    one-cycle pulse when a pass has finished
//   busy_out           high while a pass is in progress
//   tick_overrun_out   sticky: a tick arrived while busy (cleared by reset)
//   fsm_state_out      current FSM state (debug visibility)
//
// Handshake: sample_tick_in is accepted only while busy_out is low; a tick
// seen while busy_out is high is dropped and recorded in tick_overrun_out.
// update_done_out marks completion of every accepted tick exactly once,
// NUM_OSCILLATORS+1 cycles after the tick.

module osc_index_gen #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int WW_WIDTH        = 18,
    parameter int INC_WIDTH       = 16,
    parameter int PHASE_FRAC      = 8
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 sample_tick_in,
    input  logic [WW_WIDTH-1:0]                  wave_width_in,
    input  logic                                 ui_update_trig_in,
    input  logic [NUM_OSCILLATORS-1:0]           note_on_in,
    input  logic [INC_WIDTH*NUM_OSCILLATORS-1:0] phase_inc_in,
    output logic [NUM_OSCILLATORS-1:0]           osc_is_on_out,
    output logic [WW_WIDTH*NUM_OSCILLATORS-1:0]  osc_index_out,
    output logic                                 update_done_out,
    output logic                                 busy_out,
    output logic                                 tick_overrun_out,
    output logic [1:0]                           fsm_state_out
);

    localparam int ACC_W  = WW_WIDTH + PHASE_FRAC;
    localparam int SLOT_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_OSCILLATORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [WW_WIDTH-1:0]         width_q;
    logic                        restart_q;
    logic                        pending_q;
    logic                        overrun_q;
    logic [ACC_W-1:0]            acc_q [NUM_OSCILLATORS];
    logic [NUM_OSCILLATORS-1:0]  on_q;

    // Values for the slot currently being serviced
    logic [ACC_W-1:0]            cur_acc;
    logic [INC_WIDTH-1:0]        cur_inc;
    logic                        cur_note;
    logic                        cur_on;
    logic [ACC_W:0]              sum;
    logic [ACC_W:0]              sub;
    logic [ACC_W:0]              width_ext;
    logic [ACC_W-1:0]            new_acc;
    logic                        new_on;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick_in) begin
                    state_d = ST_UPDATE;
                    slot_d  = '0;
                end
            end
            ST_UPDATE: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot datapath
    // ------------------------------------------------------------------
    always_comb begin
        cur_acc  = '0;
        cur_inc  = '0;
        cur_note = 1'b0;
        cur_on   = 1'b0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_acc  = acc_q[i];
                cur_inc  = phase_inc_in[i*INC_WIDTH +: INC_WIDTH];
                cur_note = note_on_in[i];
                cur_on   = on_q[i];
            end
        end

        // One extra bit so a carry out of the accumulator still compares
        // as past the end of the wave.
        width_ext = {1'b0, width_q, {PHASE_FRAC{1'b0}}};
        sum       = {1'b0, cur_acc} + (ACC_W+1)'(cur_inc);
        sub       = sum - width_ext;

        new_acc = '0;
        new_on  = 1'b0;
        if (!cur_note || (width_q == '0)) begin
            new_acc = '0;
            new_on  = 1'b0;
        end else if (!cur_on || restart_q) begin
            // note start, or wave reload: restart from sample 0
            new_acc = '0;
            new_on  = 1'b1;
        end else if (sum >= width_ext) begin
            // single wrap; an increment larger than the wave resets to 0
            new_acc = (sub >= width_ext) ? '0 : sub[ACC_W-1:0];
            new_on  = 1'b1;
        end else begin
            new_acc = sum[ACC_W-1:0];
            new_on  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            width_q   <= '0;
            restart_q <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            on_q      <= '0;
            for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;

            // A reload request arriving with the accepted tick applies to
            // that pass; otherwise it waits for the next one.
            if ((state_q == ST_IDLE) && sample_tick_in) begin
                width_q   <= wave_width_in;
                restart_q <= pending_q | ui_update_trig_in;
                pending_q <= 1'b0;
            end else if (ui_update_trig_in) begin
                pending_q <= 1'b1;
            end

            if (sample_tick_in && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end

            if (state_q == ST_UPDATE) begin
                for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                    if (slot_q == SLOT_W'(i)) begin
                        acc_q[i] <= new_acc;
                        on_q[i]  <= new_on;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        osc_index_out = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            osc_index_out[i*WW_WIDTH +: WW_WIDTH] = acc_q[i][ACC_W-1:PHASE_FRAC];
        end
    end

    assign osc_is_on_out    = on_q;
    assign update_done_out  = (state_q == ST_DONE);
    assign busy_out         = (state_q != ST_IDLE);
    assign tick_overrun_out = overrun_q;
    assign fsm_state_out    = state_q;

endmodule

// File: tb/tb_osc_index_gen.sv
// Bench for osc_index_gen: a table of single-oscillator passes with
// hand-computed indices, then directed multi-cycle sequences for wave reload,
// mid-pass width change, tick overrun and reset during a pass.

module tb_osc_index_gen;

    localparam int N   = 4;
    localparam int WW  = 18;
    localparam int INC = 16;
    localparam int PF  = 8;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_tick_in;
    logic [WW-1:0]     wave_width_in;
    logic              ui_update_trig_in;
    logic [N-1:0]      note_on_in;
    logic [INC*N-1:0]  phase_inc_in;
    logic [N-1:0]      osc_is_on_out;
    logic [WW*N-1:0]   osc_index_out;
    logic              update_done_out;
    logic              busy_out;
    logic              tick_overrun_out;
    logic [1:0]        fsm_state_out;

    always #5 clk = ~clk;

    osc_index_gen #(
        .NUM_OSCILLATORS(N),
        .WW_WIDTH(WW),
        .INC_WIDTH(INC),
        .PHASE_FRAC(PF)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .sample_tick_in(sample_tick_in),
        .wave_width_in(wave_width_in),
        .ui_update_trig_in(ui_update_trig_in),
        .note_on_in(note_on_in),
        .phase_inc_in(phase_inc_in),
        .osc_is_on_out(osc_is_on_out),
        .osc_index_out(osc_index_out),
        .update_done_out(update_done_out),
        .busy_out(busy_out),
        .tick_overrun_out(tick_overrun_out),
        .fsm_state_out(fsm_state_out)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [WW*N-1:0] snap_idx [0:12];
    logic [N-1:0]    snap_on  [0:12];

    // ------------------------------------------------------------------
    // Driver tasks (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full pass: tick (optionally with reload), then wave_width_in is
    // driven to mid_w for the rest of the pass.
    task automatic run_pass(input logic trig, input logic [WW-1:0] mid_w);
        int lat;
        lat = 0;
        sample_tick_in    = 1'b1;
        ui_update_trig_in = trig;
        @(negedge clk);
        sample_tick_in    = 1'b0;
        ui_update_trig_in = 1'b0;
        wave_width_in     = mid_w;
        for (int k = 1; k <= 12; k++) begin
            snap_idx[k] = osc_index_out;
            snap_on[k]  = osc_is_on_out;
            if (k == 1) check("busy_in_pass", busy_out, 1'b1);
            if (update_done_out) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("done_latency", lat, 5);
        @(negedge clk);
        check("done_one_cycle", update_done_out, 1'b0);
        check("busy_after_pass", busy_out, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Vector table: oscillator 0 only, others gated off
    // ------------------------------------------------------------------
    typedef struct {
        logic [WW-1:0]  width;
        logic [N-1:0]   note;
        logic [INC-1:0] inc0;
        logic           trig;
        logic [WW-1:0]  exp_idx;
        logic           exp_on;
    } vec_t;

    vec_t vt [18];

    initial begin
        int dones;

        vt[0]  = '{18'd1000, 4'b0001, 16'h0180, 1'b0, 18'd0, 1'b1}; // note start
        vt[1]  = '{18'd1000, 4'b0001, 16'h0180, 1'b0, 18'd1, 1'b1}; // 1.5
        vt[2]  = '{18'd1000, 4'b0001, 16'h0180, 1'b0, 18'd3, 1'b1}; // 3.0
        vt[3]  = '{18'd1000, 4'b0001, 16'h0180, 1'b0, 18'd4, 1'b1}; // 4.5
        vt[4]  = '{18'd10,   4'b0001, 16'h0180, 1'b0, 18'd6, 1'b1}; // 6.0
        vt[5]  = '{18'd10,   4'b0001, 16'h0180, 1'b0, 18'd7, 1'b1}; // 7.5
        vt[6]  = '{18'd10,   4'b0001, 16'h0180, 1'b0, 18'd9, 1'b1}; // 9.0
        vt[7]  = '{18'd10,   4'b0001, 16'h0300, 1'b0, 18'd2, 1'b1}; // 12 -> 2
        vt[8]  = '{18'd10,   4'b0001, 16'h0700, 1'b0, 18'd9, 1'b1}; // 9.0
        vt[9]  = '{18'd10,   4'b0001, 16'h1400, 1'b0, 18'd0, 1'b1}; // 29 -> 0
        vt[10] = '{18'd0,    4'b0001, 16'h0300, 1'b0, 18'd0, 1'b0}; // width 0
        vt[11] = '{18'd10,   4'b0001, 16'h0300, 1'b0, 18'd0, 1'b1}; // restart
        vt[12] = '{18'd10,   4'b0001, 16'h0300, 1'b0, 18'd3, 1'b1};
        vt[13] = '{18'd10,   4'b0000, 16'h0300, 1'b0, 18'd0, 1'b0}; // note off
        vt[14] = '{18'd10,   4'b0001, 16'h0300, 1'b0, 18'd0, 1'b1}; // note on
        vt[15] = '{18'd10,   4'b0001, 16'h0300, 1'b0, 18'd3, 1'b1};
        vt[16] = '{18'd10,   4'b0001, 16'h0300, 1'b1, 18'd0, 1'b1}; // reload with tick
        vt[17] = '{18'd10,   4'b0001, 16'h0300, 1'b0, 18'd3, 1'b1};

        rst_n             = 1'b0;
        sample_tick_in    = 1'b0;
        wave_width_in     = 18'd1000;
        ui_update_trig_in = 1'b0;
        note_on_in        = '0;
        phase_inc_in      = '0;
        @(negedge clk);
        do_reset();

        check("rst_index", osc_index_out, '0);
        check("rst_is_on", osc_is_on_out, '0);
        check("rst_done", update_done_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_overrun", tick_overrun_out, 1'b0);

        // ---------------- table-driven passes ----------------
        for (int v = 0; v < 18; v++) begin
            wave_width_in     = vt[v].width;
            note_on_in        = vt[v].note;
            phase_inc_in      = '0;
            phase_inc_in[15:0] = vt[v].inc0;
            run_pass(vt[v].trig, vt[v].width);
            check($sformatf("vec%0d_idx0", v), osc_index_out[WW-1:0], vt[v].exp_idx);
            check($sformatf("vec%0d_idx_others", v), osc_index_out[WW*N-1:WW], '0);
            check($sformatf("vec%0d_on", v), osc_is_on_out, {3'b000, vt[v].exp_on});
        end

        // ---------------- wave reload with three voices ----------------
        do_reset();
        wave_width_in = 18'd1000;
        note_on_in    = 4'b0111;
        phase_inc_in  = {16'h0000, 16'h0300, 16'h0200, 16'h0100};
        run_pass(1'b0, 18'd1000);
        check("reload_start_idx", osc_index_out, {18'd0, 18'd0, 18'd0, 18'd0});
        check("reload_start_on", osc_is_on_out, 4'b0111);
        run_pass(1'b0, 18'd1000);
        run_pass(1'b0, 18'd1000);
        check("reload_pre_idx", osc_index_out, {18'd0, 18'd6, 18'd4, 18'd2});

        ui_update_trig_in = 1'b1;
        @(negedge clk);
        ui_update_trig_in = 1'b0;
        @(negedge clk);
        check("reload_pending_no_change", osc_index_out, {18'd0, 18'd6, 18'd4, 18'd2});
        run_pass(1'b0, 18'd1000);
        // slot 0 updated after the first service edge, slot 1 not yet
        check("slot_timing_k2", snap_idx[2], {18'd0, 18'd6, 18'd4, 18'd0});
        check("slot_timing_k3", snap_idx[3], {18'd0, 18'd6, 18'd0, 18'd0});
        check("reload_idx", osc_index_out, '0);
        check("reload_on", osc_is_on_out, 4'b0111);

        // width driven to 2 mid-pass must not affect this pass
        run_pass(1'b0, 18'd2);
        check("mid_width_idx", osc_index_out, {18'd0, 18'd3, 18'd2, 18'd1});
        wave_width_in = 18'd1000;

        // ---------------- tick overrun ----------------
        dones = 0;
        sample_tick_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (update_done_out) dones++;
            if (k == 3) check("overrun_set", tick_overrun_out, 1'b1);
            sample_tick_in = (k == 2);
        end
        check("overrun_single_done", dones, 1);
        check("overrun_idx", osc_index_out, {18'd0, 18'd6, 18'd4, 18'd2});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("overrun_cleared", tick_overrun_out, 1'b0);

        // ---------------- reset during slot 2 ----------------
        run_pass(1'b0, 18'd1000);
        run_pass(1'b0, 18'd1000);
        check("prerst_idx", osc_index_out, {18'd0, 18'd3, 18'd2, 18'd1});
        sample_tick_in = 1'b1;
        @(negedge clk);
        sample_tick_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_idx", osc_index_out, '0);
        check("midrst_on", osc_is_on_out, '0);
        check("midrst_busy", busy_out, 1'b0);
        check("midrst_done", update_done_out, 1'b0);
        check("midrst_overrun", tick_overrun_out, 1'b0);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (update_done_out) dones++;
        end
        check("midrst_no_done", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
